// File: rtl/video_timing_rx.sv
// video_timing_rx: receive side of a raster timing generator. Registers the
// incoming hsync/vsync/de stream, recovers active-area pixel coordinates and
// measures line/frame geometry, declaring lock once the geometry repeats.
module video_timing_rx #(
  parameter int   CORDW       = 16,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
  output logic             de_o,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             line_o,
  output logic             frame_o,
  output logic [CORDW-1:0] h_total,
  output logic [CORDW-1:0] h_active,
  output logic [CORDW-1:0] v_total,
  output logic [CORDW-1:0] v_active,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [CORDW-1:0] CMAX    = '1;
  localparam logic [CORDW-1:0] CMAX_M1 = {{(CORDW-1){1'b1}}, 1'b0};
  localparam logic [CORDW-1:0] ONE     = {{(CORDW-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_M1 = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {ARM, MEAS, LOCK} state_e;

  // stage 1 (s1) and the previous s1 value, both with syncs normalised to active-high
  logic hs1_q, vs1_q, de1_q;
  logic hs2_q, vs2_q, de2_q;
  logic hs_edge, vs_edge, de_rise, de_fall;

  // measurement counters
  logic [CORDW-1:0] hc_q, line_len_q, run_q, run_len_q, vc_q, ac_q;
  logic             sat;

  // coordinate outputs
  logic             de_q, line_q, frame_q, first_q;
  logic [CORDW-1:0] sx_q, sy_q;

  // frame state machine and published geometry
  state_e           state_q;
  logic [3:0]       match_cnt_q, match_nxt;
  logic             base_q, geo_eq;
  logic             meas_valid_q, locked_q, err_q;
  logic [CORDW-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
  logic [CORDW-1:0] pub_ht, pub_ha, pub_vt, pub_va;

  // register inputs and keep one cycle of history for edge detection
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de1_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      de2_q <= 1'b0;
    end else begin
      hs1_q <= (hsync_i == H_POL);
      vs1_q <= (vsync_i == V_POL);
      de1_q <= de_i;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      de2_q <= de1_q;
    end
  end

  assign hs_edge = hs1_q & ~hs2_q;
  assign vs_edge = vs1_q & ~vs2_q;
  assign de_rise = de1_q & ~de2_q;
  assign de_fall = ~de1_q & de2_q;

  // hc reaching its ceiling means hsync has gone missing; fires once per loss
  assign sat = ~hs_edge & (hc_q == CMAX_M1);

  // line length, de-run length, line and active-line counters
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hc_q       <= '0;
      line_len_q <= '0;
      run_q      <= '0;
      run_len_q  <= '0;
      vc_q       <= '0;
      ac_q       <= '0;
    end else begin
      if (hs_edge) begin
        hc_q       <= ONE;
        line_len_q <= hc_q;
      end else if (hc_q != CMAX) begin
        hc_q <= hc_q + ONE;
      end
      if (de_rise)                     run_q <= ONE;
      else if (de1_q && run_q != CMAX) run_q <= run_q + ONE;
      if (de_fall) run_len_q <= run_q;
      // vsync clear wins over a coincident hsync increment
      if (vs_edge)                       vc_q <= '0;
      else if (hs_edge && vc_q != CMAX)  vc_q <= vc_q + ONE;
      if (vs_edge)                       ac_q <= '0;
      else if (de_rise && ac_q != CMAX)  ac_q <= ac_q + ONE;
    end
  end

  // active-area coordinates; first_q holds sy at 0 for the first line after vsync
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      first_q <= 1'b1;
    end else begin
      de_q    <= de1_q;
      line_q  <= de_rise;
      frame_q <= de_rise & (first_q | vs_edge);
      if (de_rise)                    sx_q <= '0;
      else if (de1_q && sx_q != CMAX) sx_q <= sx_q + ONE;
      if (vs_edge) begin
        sy_q    <= '0;
        first_q <= ~de_rise;
      end else if (de_rise) begin
        if (first_q)           first_q <= 1'b0;
        else if (sy_q != CMAX) sy_q    <= sy_q + ONE;
      end
    end
  end

  // candidate geometry at a vsync edge and its comparison with the published set
  always_comb begin
    pub_ht    = hs_edge ? hc_q : line_len_q;
    pub_ha    = run_len_q;
    pub_vt    = vc_q + ONE;
    pub_va    = ac_q;
    geo_eq    = (pub_ht == h_total_q) && (pub_ha == h_active_q) &&
                (pub_vt == v_total_q) && (pub_va == v_active_q);
    match_nxt = 4'd0;
    if (base_q && geo_eq)
      match_nxt = (match_cnt_q == 4'hF) ? 4'hF : match_cnt_q + 4'd1;
  end

  // frame FSM: arm on first vsync, then publish/compare on every vsync.
  // The first publish after arming is a fresh baseline, not a mismatch.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARM;
      match_cnt_q  <= '0;
      base_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (sat) begin
        err_q       <= 1'b1;
        locked_q    <= 1'b0;
        state_q     <= ARM;
        base_q      <= 1'b0;
        match_cnt_q <= '0;
      end else if (vs_edge) begin
        if (state_q == ARM) begin
          state_q <= MEAS;
        end else begin
          h_total_q    <= pub_ht;
          h_active_q   <= pub_ha;
          v_total_q    <= pub_vt;
          v_active_q   <= pub_va;
          meas_valid_q <= 1'b1;
          base_q       <= 1'b1;
          match_cnt_q  <= match_nxt;
          if (base_q && !geo_eq) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= MEAS;
          end else if (match_nxt >= LOCK_M1) begin
            state_q  <= LOCK;
            locked_q <= 1'b1;
          end
        end
      end
    end
  end

  assign de_o       = de_q;
  assign sx         = sx_q;
  assign sy         = sy_q;
  assign line_o     = line_q;
  assign frame_o    = frame_q;
  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_video_timing_rx.sv
// tb_video_timing_rx: drives a small raster (20x10 total, 12x6 active) into two
// receivers, one with active-low syncs and one with active-high syncs fed the
// inverted stream. Expected pixels and per-vsync status are queued at drive
// time and checked by an independent monitor.
module tb_video_timing_rx;

  localparam int CW  = 8;
  localparam int SAT = 1 << CW;
  localparam int HA = 12, HSW = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VSW = 1, VT = 10;

  typedef struct {
    int cyc; int sx; int sy; bit ln; bit fr;
  } pix_t;

  typedef struct {
    int cyc; int ht; int ha; int vt; int va;
    bit valid; bit lck; bit er; bit rchk;
  } meas_t;

  logic clk_pix, rst_n, hs_n, vs_n, de_in;
  logic hs_p, vs_p;
  assign hs_p = ~hs_n;
  assign vs_p = ~vs_n;

  logic de_a, line_a, frame_a, mv_a, lk_a, err_a;
  logic de_b, line_b, frame_b, mv_b, lk_b, err_b;
  logic [CW-1:0] sx_a, sy_a, ht_a, ha_a, vt_a, va_a;
  logic [CW-1:0] sx_b, sy_b, ht_b, ha_b, vt_b, va_b;

  video_timing_rx #(.CORDW(CW), .H_POL(1'b0), .V_POL(1'b0), .LOCK_FRAMES(2)) u_neg (
    .clk_pix(clk_pix), .rst_n(rst_n), .hsync_i(hs_n), .vsync_i(vs_n), .de_i(de_in),
    .de_o(de_a), .sx(sx_a), .sy(sy_a), .line_o(line_a), .frame_o(frame_a),
    .h_total(ht_a), .h_active(ha_a), .v_total(vt_a), .v_active(va_a),
    .meas_valid(mv_a), .locked(lk_a), .err(err_a));

  video_timing_rx #(.CORDW(CW), .H_POL(1'b1), .V_POL(1'b1), .LOCK_FRAMES(2)) u_pos (
    .clk_pix(clk_pix), .rst_n(rst_n), .hsync_i(hs_p), .vsync_i(vs_p), .de_i(de_in),
    .de_o(de_b), .sx(sx_b), .sy(sy_b), .line_o(line_b), .frame_o(frame_b),
    .h_total(ht_b), .h_active(ha_b), .v_total(vt_b), .v_active(va_b),
    .meas_valid(mv_b), .locked(lk_b), .err(err_b));

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    sy_off = 0;
  int    last_hs = 0;
  pix_t  pq[$];
  meas_t mq[$];
  meas_t cur_exp;
  pix_t  mon_p;
  meas_t mon_m;

  initial begin
    clk_pix = 1'b0;
    forever #5 clk_pix = ~clk_pix;
  end

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk2(input string nm, input int a, input int b, input int exp);
    chk({nm, " (neg syncs)"}, a, exp);
    chk({nm, " (pos syncs)"}, b, exp);
  endtask

  function automatic meas_t mk(input int ht, input int ha, input int vt, input int va,
                               input bit valid, input bit lck, input bit er);
    meas_t m;
    m.cyc = 0; m.ht = ht; m.ha = ha; m.vt = vt; m.va = va;
    m.valid = valid; m.lck = lck; m.er = er; m.rchk = 1'b0;
    return m;
  endfunction

  // monitor: pixel scoreboard plus status checked at the queued cycles
  always @(negedge clk_pix) begin
    if (pq.size() > 0 && pq[0].cyc == cyc) begin
      mon_p = pq.pop_front();
      chk2("de_o", de_a, de_b, 1);
      chk2("sx", sx_a, sx_b, mon_p.sx);
      chk2("sy", sy_a, sy_b, mon_p.sy);
      chk2("line_o", line_a, line_b, mon_p.ln);
      chk2("frame_o", frame_a, frame_b, mon_p.fr);
    end else if (de_a | de_b | line_a | line_b | frame_a | frame_b) begin
      n_chk++;
      n_fail++;
      $display("FAIL pixel_unexpected: de_o %0d/%0d line_o %0d/%0d frame_o %0d/%0d required all 0 at cycle %0d",
               de_a, de_b, line_a, line_b, frame_a, frame_b, cyc);
    end
    if (mq.size() > 0 && mq[0].cyc == cyc) begin
      mon_m = mq.pop_front();
      chk2("h_total", ht_a, ht_b, mon_m.ht);
      chk2("h_active", ha_a, ha_b, mon_m.ha);
      chk2("v_total", vt_a, vt_b, mon_m.vt);
      chk2("v_active", va_a, va_b, mon_m.va);
      chk2("meas_valid", mv_a, mv_b, mon_m.valid);
      chk2("locked", lk_a, lk_b, mon_m.lck);
      chk2("err", err_a, err_b, mon_m.er);
      if (mon_m.rchk) begin
        chk2("reset de_o", de_a, de_b, 0);
        chk2("reset sx", sx_a, sx_b, 0);
        chk2("reset sy", sy_a, sy_b, 0);
        chk2("reset line_o", line_a, line_b, 0);
        chk2("reset frame_o", frame_a, frame_b, 0);
      end
    end else if (err_a | err_b) begin
      n_chk++;
      n_fail++;
      $display("FAIL err_unexpected: err %0d/%0d required 0 at cycle %0d", err_a, err_b, cyc);
    end
  end

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hs_n = 1'b1; vs_n = 1'b1; de_in = 1'b0;
    end
  endtask

  // one pixel-clock of the raster; vsync edges coincide with the hsync leading edge
  task automatic drive_cycle(input int x, input int y, input int ht, input int rst_line);
    int    hs0, yv;
    bit    hs_act, vs_act, de;
    meas_t m;
    pix_t  p;
    hs0    = ht - HSW - HBP;
    hs_act = (x >= hs0) && (x < hs0 + HSW);
    yv     = (x >= hs0) ? y : ((y == 0) ? VT - 1 : y - 1);
    vs_act = (yv >= VA + VFP) && (yv < VA + VFP + VSW);
    de     = (x < HA) && (y < VA);
    tick();
    if (y == rst_line && x == 6) begin
      rst_n = 1'b0;
      while (pq.size() > 0 && pq[$].cyc >= cyc) void'(pq.pop_back());
      m = mk(0, 0, 0, 0, 0, 0, 0);
      m.cyc = cyc; m.rchk = 1'b1;
      mq.push_back(m);
      sy_off = rst_line + 1;
    end
    if (y == rst_line && x == 13) rst_n = 1'b1;
    hs_n  = ~hs_act;
    vs_n  = ~vs_act;
    de_in = de;
    if (de && rst_n) begin
      p.cyc = cyc + 2; p.sx = x; p.sy = y - sy_off;
      p.ln = (x == 0); p.fr = (x == 0) && (y == sy_off);
      pq.push_back(p);
    end
    if (x == hs0) last_hs = cyc;
    if (x == hs0 && y == VA + VFP) begin
      m = cur_exp;
      m.cyc = cyc + 2;
      mq.push_back(m);
    end
  endtask

  task automatic run_frame(input int ht, input meas_t e, input int rst_line);
    cur_exp = e;
    sy_off  = 0;
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < ht; x++)
        drive_cycle(x, y, ht, rst_line);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    meas_t m;
    rst_n = 1'b0; hs_n = 1'b1; vs_n = 1'b1; de_in = 1'b0;
    tick();
    tick();
    m = mk(0, 0, 0, 0, 0, 0, 0);
    m.cyc = cyc; m.rchk = 1'b1;
    mq.push_back(m);
    tick();
    rst_n = 1'b1;

    // power-up: arm, baseline, lock
    run_frame(20, mk(0, 0, 0, 0, 0, 0, 0), -1);
    run_frame(20, mk(20, 12, 10, 6, 1, 0, 0), -1);
    run_frame(20, mk(20, 12, 10, 6, 1, 1, 0), -1);
    run_frame(20, mk(20, 12, 10, 6, 1, 1, 0), -1);
    // line length grows to 21: mismatch, then relock
    run_frame(21, mk(21, 12, 10, 6, 1, 0, 1), -1);
    run_frame(21, mk(21, 12, 10, 6, 1, 1, 0), -1);
    // hsync lost: hc saturates 2^CW cycles after the last hsync leading edge
    m = mk(21, 12, 10, 6, 1, 0, 1);
    m.cyc = last_hs + SAT;
    mq.push_back(m);
    idle(300);
    // resumed stream: first vsync only re-arms, old values stay published
    run_frame(20, mk(21, 12, 10, 6, 1, 0, 0), -1);
    run_frame(20, mk(20, 12, 10, 6, 1, 0, 0), -1);
    run_frame(20, mk(20, 12, 10, 6, 1, 1, 0), -1);
    // reset pulsed in the middle of active line 2
    run_frame(20, mk(0, 0, 0, 0, 0, 0, 0), 2);
    run_frame(20, mk(20, 12, 10, 6, 1, 0, 0), -1);
    run_frame(20, mk(20, 12, 10, 6, 1, 1, 0), -1);

    idle(10);
    chk("pixel queue drained", pq.size(), 0);
    chk("status queue drained", mq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
